task_deser: RTL and testbench
=============================

TASK_DESER -- requirements
Module: task_deser

Interface
REQ-001 Parameter: SYNC_BYTE, 8'hA5, frame start marker.
REQ-002 Parameter: TIMEOUT_CYCLES, 1023, maximum idle cycles between bytes inside a frame; 0 disables the timeout.
REQ-003 Port: clock  input  1  sole clock, rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_data  input  8  host byte stream.
REQ-006 Port: in_valid  input  1  in_data valid.
REQ-007 Port: in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 Port: output_data  output  144  assembled task {player[63:0], opponent[63:0], taskid[15:0]}; connects to the 144-bit task input of the solver feed stage.
REQ-009 Port: output_valid  output  1  output_data holds a task.
REQ-010 Port: output_ready  input  1  consumer accepts the task when output_valid && output_ready.
REQ-011 Port: drop_count  output  8  frames discarded since reset; saturates at 255.

Function
REQ-012 States SHALL be HUNT, COLLECT and WAIT_OUT; with the checksum feature enabled, a CHECK phase is added (REQ-027).
REQ-013 HUNT: in_ready=1; accepted byte equal to SYNC_BYTE -> COLLECT with byte index=0; any other byte is discarded without counting.
REQ-014 COLLECT: payload bytes SHALL shift in MSB-first, so payload byte 0 lands in bits [143:136] and byte 17 in bits [7:0].
REQ-015 A SYNC_BYTE value inside a payload SHALL be treated as data; there is no mid-frame resync.
REQ-016 The assembly register and the output register SHALL be separate, so a new frame can be collected while the previous task waits on output_ready.
REQ-017 Completion with output slot empty, or draining in the same cycle: the task loads into the output register at the next edge, output_valid=1 one cycle after the final byte is accepted, and the state returns to HUNT.
REQ-018 Completion with output slot full and not draining: go to WAIT_OUT with in_ready=0; load the task on the cycle the slot drains; output_valid stays continuously 1 across the handover; then return to HUNT.
REQ-019 output_data SHALL stay stable while output_valid=1 && output_ready=0.
REQ-020 Gap counter: increments on each COLLECT cycle with no accepted byte and clears on every accepted byte.
REQ-021 When the gap counter reaches TIMEOUT_CYCLES (nonzero), the frame is dropped, drop_count increments, the state goes to HUNT, and the output register is unaffected.
REQ-022 Sustained throughput SHALL be one byte per cycle in HUNT and COLLECT.

Reset
REQ-023 reset SHALL be sampled only on the rising clock edge and SHALL override all other activity.
REQ-024 Reset values: state=HUNT, byte index=0, gap counter=0, output_valid=0, output_data=0, drop_count=0, in_ready=1 in the first cycle after reset.
REQ-025 Reset mid-frame or mid-WAIT_OUT SHALL discard both the partial frame and any held task.

Configuration
REQ-026 Macro TASK_DESER_CHECKSUM_EN, when defined, makes each frame carry a 19th byte equal to the XOR of the 18 payload bytes.
REQ-027 With the macro defined: checksum match completes the frame per REQ-017/018; mismatch drops the frame, increments drop_count and returns to HUNT; the checksum byte is never part of output_data.
REQ-028 With the macro undefined: frames are 18 payload bytes, no checksum logic exists, and drop_count counts timeouts only.

Structure
REQ-029 Shared package othello_task_pkg SHALL hold TASK_BYTES=18, TASK_WIDTH=144, the field widths 64/64/16 and the state enum.
REQ-030 One sub-module, deser_gap_timer, SHALL implement the gap counter and timeout flag; the output register stays inline.

Verification
REQ-031 A5 then bytes 01..12 (hex), output_ready=1 -> output_valid=1 one cycle after the last byte; output_data=0x0102...1112; taskid=0x1112.
REQ-032 Bytes 00, FF, then the REQ-031 frame -> same output_data; drop_count=0.
REQ-033 output_ready=0 with two back-to-back frames -> first task held stable; in_ready=0 after the second frame's final byte; output_ready pulse -> second task presented with no output_valid gap.
REQ-034 TIMEOUT_CYCLES=16, frame stopped after 7 payload bytes -> after 16 idle cycles drop_count=1 and state=HUNT; the next full frame decodes correctly.
REQ-035 TASK_DESER_CHECKSUM_EN defined: REQ-031 payload plus checksum 0x13 -> task output; same payload plus 0x00 -> no output, drop_count=1.
REQ-036 reset asserted after 10 payload bytes -> output_valid=0 and drop_count=0; the following full frame decodes correctly.

Source files
------------

// File: rtl/task_deser_pkg.sv
// Shared constants and types for the Othello task deserializer.
// Defining TASK_DESER_CHECKSUM_EN adds the CHECK state to the state enum.
package othello_task_pkg;

   localparam int TASK_BYTES = 18;
   localparam int PLAYER_W   = 64;
   localparam int OPPONENT_W = 64;
   localparam int TASKID_W   = 16;
   localparam int TASK_WIDTH = PLAYER_W + OPPONENT_W + TASKID_W;
   localparam int IDX_W      = $clog2(TASK_BYTES + 1);

   typedef struct packed {
      logic [PLAYER_W-1:0]   player;
      logic [OPPONENT_W-1:0] opponent;
      logic [TASKID_W-1:0]   taskid;
   } task_t;

`ifdef TASK_DESER_CHECKSUM_EN
   typedef enum logic [1:0] {
      HUNT     = 2'd0,
      COLLECT  = 2'd1,
      WAIT_OUT = 2'd2,
      CHECK    = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      HUNT     = 2'd0,
      COLLECT  = 2'd1,
      WAIT_OUT = 2'd2
   } state_t;
`endif

endpackage

// File: rtl/task_deser_if.sv
// Byte-stream input and task output bundle of task_deser.
interface task_deser_if;
   import othello_task_pkg::*;

   // Both streams use strict valid/ready: a transfer happens on a rising edge
   // where valid && ready; once raised, valid and its data hold until that edge.
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [TASK_WIDTH-1:0] output_data;
   logic                  output_valid;
   logic                  output_ready;
   logic [7:0]            drop_count;

   modport master (
      output in_data, in_valid, output_ready,
      input  in_ready, output_data, output_valid, drop_count
   );

   modport slave (
      input  in_data, in_valid, output_ready,
      output in_ready, output_data, output_valid, drop_count
   );

endinterface

// File: rtl/task_deser_gap_timer.sv
// Counts idle cycles inside a frame; timeout_o fires on the TIMEOUT_CYCLES-th
// consecutive idle cycle so the frame is dropped at that edge. 0 disables it.
module deser_gap_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic clock,
   input  logic reset,
   input  logic active_i,
   input  logic accept_i,
   output logic timeout_o
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [CW-1:0] gap_q, gap_d;
   logic          idle;

   always_comb begin
      idle      = active_i && !accept_i;
      timeout_o = (TIMEOUT_CYCLES != 0) && idle && (gap_q == LAST);
      if (!idle || timeout_o) gap_d = '0;
      else                    gap_d = gap_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) gap_q <= '0;
      else       gap_q <= gap_d;
   end

endmodule

// File: rtl/task_deser.sv
// Hunts for SYNC_BYTE, assembles an 18-byte task and hands it out on a held
// output register. TASK_DESER_CHECKSUM_EN adds a trailing XOR checksum byte.
module task_deser
   import othello_task_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic          clock,
   input  logic          reset,
   task_deser_if.slave   bus,
   output state_t        dbg_state_o
);

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [TASK_WIDTH-1:0] asm_q, asm_d;
   logic [TASK_WIDTH-1:0] out_q, out_d;
   logic                  out_valid_q, out_valid_d;
   logic [7:0]            drop_q, drop_d;

   logic                  in_ready, collecting, timeout;
   logic                  accept, sync_hit, shift_en, last_byte, slot_free;
   logic                  complete, drop_frame;
   logic [TASK_WIDTH-1:0] shifted, done_data;
`ifdef TASK_DESER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
   logic                  bad_sum;
`endif

   deser_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
      .clock     (clock),
      .reset     (reset),
      .active_i  (collecting),
      .accept_i  (accept),
      .timeout_o (timeout)
   );

   always_comb begin
      in_ready   = (state_q != WAIT_OUT);
`ifdef TASK_DESER_CHECKSUM_EN
      collecting = (state_q == COLLECT) || (state_q == CHECK);
`else
      collecting = (state_q == COLLECT);
`endif
   end

   // A task completes either on its last payload byte or on a matching checksum.
   always_comb begin
      accept    = bus.in_valid && in_ready;
      sync_hit  = (state_q == HUNT) && accept && (bus.in_data == SYNC_BYTE);
      shift_en  = (state_q == COLLECT) && accept;
      last_byte = shift_en && (idx_q == IDX_W'(TASK_BYTES - 1));
      shifted   = {asm_q[TASK_WIDTH-9:0], bus.in_data};
      slot_free = !out_valid_q || bus.output_ready;
`ifdef TASK_DESER_CHECKSUM_EN
      complete   = (state_q == CHECK) && accept && (bus.in_data == csum_q);
      bad_sum    = (state_q == CHECK) && accept && (bus.in_data != csum_q);
      done_data  = asm_q;
      drop_frame = timeout || bad_sum;
`else
      complete   = last_byte;
      done_data  = shifted;
      drop_frame = timeout;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= HUNT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HUNT: if (sync_hit) state_d = COLLECT;
         COLLECT: begin
            if (timeout) state_d = HUNT;
`ifdef TASK_DESER_CHECKSUM_EN
            else if (last_byte) state_d = CHECK;
         end
         CHECK: begin
            if (timeout || bad_sum) state_d = HUNT;
            else if (complete) state_d = slot_free ? HUNT : WAIT_OUT;
         end
`else
            else if (complete) state_d = slot_free ? HUNT : WAIT_OUT;
         end
`endif
         WAIT_OUT: if (bus.output_ready) state_d = HUNT;
         default:  state_d = HUNT;
      endcase
   end

   always_comb begin
      idx_d       = idx_q;
      asm_d       = asm_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      drop_d      = drop_q;
`ifdef TASK_DESER_CHECKSUM_EN
      csum_d      = csum_q;
      if (sync_hit) csum_d = '0;
      if (shift_en) csum_d = csum_q ^ bus.in_data;
`endif
      if (sync_hit) idx_d = '0;
      if (shift_en) begin
         asm_d = shifted;
         idx_d = idx_q + 1'b1;
      end
      if (out_valid_q && bus.output_ready) out_valid_d = 1'b0;
      // Loads only happen when the slot is empty or draining, so a stalled task never changes.
      if (complete && slot_free) begin
         out_d       = done_data;
         out_valid_d = 1'b1;
      end
      if ((state_q == WAIT_OUT) && bus.output_ready) begin
         out_d       = asm_q;
         out_valid_d = 1'b1;
      end
      if (drop_frame && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idx_q       <= '0;
         asm_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         drop_q      <= '0;
`ifdef TASK_DESER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         drop_q      <= drop_d;
`ifdef TASK_DESER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.output_data  = out_q;
   assign bus.output_valid = out_valid_q;
   assign bus.drop_count   = drop_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_task_deser.sv
// Bench for task_deser: directed frames plus randomized traffic checked against
// a queue of expected tasks and an expected drop count.
module tb_task_deser;
   import othello_task_pkg::*;

   localparam int unsigned         TMO   = 16;
   localparam logic [7:0]          SYNC  = 8'hA5;
   localparam logic [TASK_WIDTH-1:0] T_REF = 144'h0102030405060708090a0b0c0d0e0f101112;

   logic   clock = 1'b0;
   logic   reset = 1'b1;
   state_t dbg_state;

   task_deser_if bus_if ();

   task_deser #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus_if),
      .dbg_state_o (dbg_state)
   );

   always #5 clock = ~clock;

   int                    checks    = 0;
   int                    errors    = 0;
   int                    exp_drops = 0;
   logic [TASK_WIDTH-1:0] exp_q[$];
   bit                    rand_rdy   = 1'b0;
   bit                    stall_seen = 1'b0;
   logic [TASK_WIDTH-1:0] held;

   task automatic check(input string tag, input logic [TASK_WIDTH-1:0] obs,
                        input logic [TASK_WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
      if (rand_rdy) bus_if.output_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      bus_if.in_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit took = 1'b0;
      bus_if.in_data  = b;
      bus_if.in_valid = 1'b1;
      for (int n = 0; n < 200 && !took; n++) begin
         @(negedge clock);
         took = bus_if.in_ready;
         cycle();
      end
      check("byte_accept", took, 1);
   endtask

   function automatic logic [7:0] pbyte(input logic [TASK_WIDTH-1:0] t, input int i);
      return t[TASK_WIDTH-1-8*i -: 8];
   endfunction

   function automatic logic [7:0] csum(input logic [TASK_WIDTH-1:0] t);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < TASK_BYTES; i++) x ^= pbyte(t, i);
      return x;
   endfunction

   task automatic send_part(input logic [TASK_WIDTH-1:0] t, input int lo, input int hi);
      for (int i = lo; i < hi; i++) send_byte(pbyte(t, i));
   endtask

   task automatic send_frame(input logic [TASK_WIDTH-1:0] t, input int gap_max);
      send_byte(SYNC);
      for (int i = 0; i < TASK_BYTES; i++) begin
         if (gap_max > 0) idle($urandom_range(0, gap_max));
         send_byte(pbyte(t, i));
      end
`ifdef TASK_DESER_CHECKSUM_EN
      send_byte(csum(t));
`endif
   endtask

   function automatic logic [TASK_WIDTH-1:0] rand_task();
      return {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
   endfunction

   task automatic do_reset(input int n);
      reset           = 1'b1;
      bus_if.in_valid = 1'b0;
      repeat (n) cycle();
      reset = 1'b0;
      exp_q.delete();
      exp_drops = 0;
   endtask

   task automatic drain(input string tag);
      bus_if.in_valid     = 1'b0;
      rand_rdy            = 1'b0;
      bus_if.output_ready = 1'b1;
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) cycle();
      cycle();
      check({tag, "_queue"}, exp_q.size(), 0);
      check({tag, "_valid"}, bus_if.output_valid, 0);
   endtask

   // Scoreboard: every handshake must deliver the oldest expected task, and a stalled task must hold.
   always @(negedge clock) begin
      if (reset) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check("hold_valid", bus_if.output_valid, 1);
            check("hold_data", bus_if.output_data, held);
         end
         if (bus_if.output_valid && bus_if.output_ready) begin
            check("task_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("task_data", bus_if.output_data, exp_q.pop_front());
         end
         stall_seen = bus_if.output_valid && !bus_if.output_ready;
         held       = bus_if.output_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TASK_WIDTH-1:0] t1, t2, t3, t4;
      int                    kind, k;
      bus_if.in_data      = 8'h00;
      bus_if.in_valid     = 1'b0;
      bus_if.output_ready = 1'b0;
      do_reset(3);
      check("rst_valid", bus_if.output_valid, 0);
      check("rst_data", bus_if.output_data, 0);
      check("rst_drop", bus_if.drop_count, 0);
      check("rst_in_ready", bus_if.in_ready, 1);
      check("rst_state", dbg_state, HUNT);

      // Reference frame with exact output latency.
      bus_if.output_ready = 1'b1;
      exp_q.push_back(T_REF);
      send_byte(SYNC);
      send_part(T_REF, 0, TASK_BYTES - 1);
      check("ref_pre_last_valid", bus_if.output_valid, 0);
      send_byte(8'h12);
`ifdef TASK_DESER_CHECKSUM_EN
      check("ref_pre_ck_valid", bus_if.output_valid, 0);
      send_byte(8'h13);
`endif
      check("ref_valid", bus_if.output_valid, 1);
      check("ref_data", bus_if.output_data, T_REF);
      check("ref_taskid", bus_if.output_data[15:0], 16'h1112);
      check("ref_state", dbg_state, HUNT);
      idle(1);
      check("ref_consumed", bus_if.output_valid, 0);

      // Junk before sync is ignored and not counted.
      exp_q.push_back(T_REF);
      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame(T_REF, 0);
      drain("junk");
      check("junk_drop", bus_if.drop_count, 0);

      // Back-to-back frames against a stalled consumer.
      bus_if.output_ready = 1'b0;
      t1 = rand_task();
      t2 = rand_task();
      exp_q.push_back(t1);
      exp_q.push_back(t2);
      send_frame(t1, 0);
      send_frame(t2, 0);
      bus_if.in_valid = 1'b0;
      check("bp_in_ready", bus_if.in_ready, 0);
      check("bp_state", dbg_state, WAIT_OUT);
      check("bp_first_data", bus_if.output_data, t1);
      idle(4);
      bus_if.output_ready = 1'b1;
      cycle();
      bus_if.output_ready = 1'b0;
      check("bp_no_gap", bus_if.output_valid, 1);
      check("bp_second_data", bus_if.output_data, t2);
      check("bp_in_ready_back", bus_if.in_ready, 1);
      check("bp_state_back", dbg_state, HUNT);
      drain("bp");

      // Timeout after 7 payload bytes lands exactly on the 16th idle cycle.
      send_byte(SYNC);
      send_part(T_REF, 0, 7);
      idle(TMO - 1);
      check("tmo_state_before", dbg_state, COLLECT);
      check("tmo_drop_before", bus_if.drop_count, 0);
      cycle();
      exp_drops++;
      check("tmo_state_after", dbg_state, HUNT);
      check("tmo_drop_after", bus_if.drop_count, exp_drops);
      exp_q.push_back(T_REF);
      send_frame(T_REF, 0);
      drain("tmo_next");

      // A 15-cycle gap is still inside the frame.
      t3 = rand_task();
      exp_q.push_back(t3);
      send_byte(SYNC);
      send_part(t3, 0, 3);
      idle(TMO - 1);
      send_part(t3, 3, TASK_BYTES);
`ifdef TASK_DESER_CHECKSUM_EN
      send_byte(csum(t3));
`endif
      drain("gap15");
      check("gap15_drop", bus_if.drop_count, exp_drops);

      // Timeout while a task is held leaves the output register alone.
      bus_if.output_ready = 1'b0;
      t4 = rand_task();
      exp_q.push_back(t4);
      send_frame(t4, 0);
      send_byte(SYNC);
      send_part(T_REF, 0, 2);
      idle(TMO);
      exp_drops++;
      check("tmo_hold_drop", bus_if.drop_count, exp_drops);
      check("tmo_hold_valid", bus_if.output_valid, 1);
      check("tmo_hold_data", bus_if.output_data, t4);
      drain("tmo_hold");

`ifdef TASK_DESER_CHECKSUM_EN
      exp_q.push_back(T_REF);
      send_frame(T_REF, 0);
      drain("ck_good");
      send_byte(SYNC);
      send_part(T_REF, 0, TASK_BYTES);
      send_byte(8'h00);
      exp_drops++;
      idle(3);
      check("ck_bad_drop", bus_if.drop_count, exp_drops);
      check("ck_bad_valid", bus_if.output_valid, 0);
`endif

      // Reset mid-frame, then mid-WAIT_OUT.
      bus_if.output_ready = 1'b1;
      send_byte(SYNC);
      send_part(T_REF, 0, 10);
      do_reset(1);
      check("rst_mid_valid", bus_if.output_valid, 0);
      check("rst_mid_drop", bus_if.drop_count, 0);
      check("rst_mid_state", dbg_state, HUNT);
      bus_if.output_ready = 1'b0;
      send_frame(rand_task(), 0);
      send_frame(rand_task(), 0);
      bus_if.in_valid = 1'b0;
      check("rst_wait_state", dbg_state, WAIT_OUT);
      do_reset(2);
      check("rst_wait_valid", bus_if.output_valid, 0);
      check("rst_wait_data", bus_if.output_data, 0);
      bus_if.output_ready = 1'b1;
      exp_q.push_back(T_REF);
      send_frame(T_REF, 0);
      drain("rst_next");

      // Randomized traffic: junk, aborted frames and good frames with gaps and stalls.
      rand_rdy = 1'b1;
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 9);
         if (kind < 2) begin
            for (int j = 0; j < $urandom_range(1, 3); j++) begin
               t1[7:0] = 8'($urandom);
               send_byte((t1[7:0] == SYNC) ? 8'h00 : t1[7:0]);
            end
         end else if (kind == 2) begin
            k = $urandom_range(0, TASK_BYTES - 1);
            send_byte(SYNC);
            send_part(rand_task(), 0, k);
            idle(TMO);
            if (exp_drops < 255) exp_drops++;
            check("rand_abort_drop", bus_if.drop_count, exp_drops);
         end else begin
            t1 = rand_task();
            exp_q.push_back(t1);
            send_frame(t1, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
         end
      end
      drain("rand_end");
      check("rand_end_drop", bus_if.drop_count, exp_drops);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
